// File: rtl/spi_master_mc.sv
// spi_master_mc: full-duplex SPI master with runtime CPOL/CPHA, programmable SCLK divider and
// one-hot active-low chip selects. Defining SPI_LSB_FIRST_EN adds the lsb_first input.
module spi_master_mc #(
    parameter int DATA_W   = 8,
    parameter int NUM_CS   = 4,
    parameter int CLK_DIV  = 2,
    parameter int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_send_enable,
    input  logic [DATA_W-1:0]   data_send_master,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic                cpol,
    input  logic                cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    input  logic                miso,
    output logic                mosi,
    output logic                sclk,
    output logic [NUM_CS-1:0]   cs,
    output logic                busy,
    output logic [DATA_W-1:0]   data_receive_master,
    output logic                data_receive_master_enable,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_e;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                strobe_q, strobe_d;

    logic                lsb_in;
    logic                sel_ok;
    logic [HP_W-1:0]     hp_next;
    logic                shift_edge;
    logic                sample_now;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    assign sel_ok  = int'(cs_sel) < NUM_CS;
    assign hp_next = hp_q + 1'b1;
    // hp_q is the current half-period (0 while in LEAD); edges of the shift type move mosi,
    // except the final trailing edge in CPHA=0 which would push past the last bit.
    assign shift_edge = (hp_next[0] == cpha_q) && !(!cpha_q && (hp_next == HP_LAST));
    assign sample_now = (state_q == XFER) && (cnt_q == '0) && (hp_q[0] != cpha_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        mosi_d   = mosi_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        strobe_d = 1'b0;

        // LSB-first receive shifts right so the word lands in natural bit order.
        if (sample_now) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (data_send_enable && sel_ok) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    hp_d    = '0;
                    tx_d    = lsb_in ? bit_reverse(data_send_master) : data_send_master;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_in;
                    cs_d    = ~(NUM_CS'(1) << cs_sel);
                    busy_d  = 1'b1;
                    if (!cpha) begin
                        mosi_d = tx_d[DATA_W-1];
                        tx_d   = tx_d << 1;
                    end
                end
            end
            LEAD, XFER: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (hp_q == HP_LAST) begin
                        state_d = TRAIL;
                        sclk_d  = cpol_q;
                    end else begin
                        state_d = XFER;
                        hp_d    = hp_next;
                        sclk_d  = cpol_q ^ hp_next[0];
                        if (shift_edge) begin
                            mosi_d = tx_q[DATA_W-1];
                            tx_d   = tx_q << 1;
                        end
                    end
                end
            end
            TRAIL: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = DONE;
                    cs_d     = '1;
                    mosi_d   = 1'b0;
                    rdata_d  = rx_q;
                    strobe_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = cpol;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hp_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            mosi_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= '1;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            mosi_q   <= mosi_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
        end
    end

    assign mosi                       = mosi_q;
    assign sclk                       = sclk_q;
    assign cs                         = cs_q;
    assign busy                       = busy_q;
    assign data_receive_master        = rdata_q;
    assign data_receive_master_enable = strobe_q;
    assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: two instances (CLK_DIV=2/NUM_CS=4 and CLK_DIV=1/NUM_CS=3) driven by an
// edge-level SPI slave model; build with SPI_LSB_FIRST_EN to cover LSB-first transfers.
module tb_spi_master_mc;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          which;
    logic [DW-1:0] data;
    logic [1:0]    sel;
    logic          cpol_drv;
    logic          cpha_drv;
    logic          lsb_drv;
    logic          miso;

    logic          en0, en1;
    logic          mosi0, sclk0, busy0, stb0;
    logic [3:0]    cs0;
    logic [DW-1:0] rd0;
    logic [2:0]    st0;
    logic          mosi1, sclk1, busy1, stb1;
    logic [2:0]    cs1;
    logic [DW-1:0] rd1;
    logic [2:0]    st1;

    logic          o_mosi, o_sclk, o_busy, o_stb;
    logic [3:0]    o_cs;
    logic [DW-1:0] o_rd;

    int tests;
    int fails;
    logic [DW-1:0] exp_q[$];

    assign en0 = en && !which;
    assign en1 = en && which;

    spi_master_mc #(.DATA_W(DW), .NUM_CS(4), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .data_send_enable(en0), .data_send_master(data),
        .cs_sel(sel), .cpol(cpol_drv), .cpha(cpha_drv),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_drv),
`endif
        .miso(miso), .mosi(mosi0), .sclk(sclk0), .cs(cs0), .busy(busy0),
        .data_receive_master(rd0), .data_receive_master_enable(stb0), .dbg_state_o(st0)
    );

    spi_master_mc #(.DATA_W(DW), .NUM_CS(3), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data_send_enable(en1), .data_send_master(data),
        .cs_sel(sel), .cpol(cpol_drv), .cpha(cpha_drv),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_drv),
`endif
        .miso(miso), .mosi(mosi1), .sclk(sclk1), .cs(cs1), .busy(busy1),
        .data_receive_master(rd1), .data_receive_master_enable(stb1), .dbg_state_o(st1)
    );

    always_comb begin
        if (which) begin
            o_mosi = mosi1; o_sclk = sclk1; o_busy = busy1; o_stb = stb1;
            o_cs = {1'b1, cs1}; o_rd = rd1;
        end else begin
            o_mosi = mosi0; o_sclk = sclk0; o_busy = busy0; o_stb = stb0;
            o_cs = cs0; o_rd = rd0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // One transfer observed cycle by cycle from the accepting cycle T (c = 0). The slave model reacts
    // to sclk transitions: it samples mosi on its sample edges and updates miso on its shift edges.
    task automatic xfer(input bit u, input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                        input logic [1:0] s, input bit pol, input bit pha,
                        input bit loopb, input bit noise, input bit settle, input bit lsbf);
        int lat, c, stb_at, trans, rises, sb, cs_bad, busy_bad, post_bad;
        logic [3:0] exp_cs;
        logic [DW-1:0] srx, mrx, exp_w;
        logic prev, lead, active, first_bit, got_first;
        lat = (2 * DW + 2) * (u ? 1 : 2) + 1;
        exp_cs = 4'hF;
        exp_cs[s] = 1'b0;
        c = 0; stb_at = -1; trans = 0; rises = 0; sb = 0; cs_bad = 0; busy_bad = 0; post_bad = 0;
        srx = '0; mrx = '0; prev = pol; active = 1'b0; first_bit = 1'b0; got_first = 1'b0;
        @(negedge clk);
        which = u;
        if (settle) begin
            en = 1'b0; cpol_drv = pol; cpha_drv = pha;
            repeat (2) @(negedge clk);
            tests++;
            if (o_sclk !== pol) begin
                fails++; $display("FAIL idle_sclk: got %b expected %b", o_sclk, pol);
            end
        end
        tests++;
        if (o_busy !== 1'b0) begin
            fails++; $display("FAIL busy_before_start: got %b expected 0", o_busy);
        end
        data = tx; sel = s; cpol_drv = pol; cpha_drv = pha; lsb_drv = lsbf; en = 1'b1; miso = 1'b0;
        exp_q.push_back(loopb ? tx : slv);
        while (c < lat + 4 && stb_at < 0) begin
            @(negedge clk);
            c++;
            if (c < lat) begin
                if (o_cs !== exp_cs) cs_bad++;
                if (o_busy !== 1'b1) busy_bad++;
            end
            if (!active && o_cs[s] == 1'b0) begin
                active = 1'b1;
                if (!pha) begin
                    miso = lsbf ? slv[sb] : slv[DW-1-sb];
                    sb++;
                end
            end
            if (o_sclk !== prev) begin
                trans++;
                if (o_sclk) rises++;
                lead = (prev == pol);
                if (lead != pha) begin
                    if (!got_first) begin first_bit = o_mosi; got_first = 1'b1; end
                    srx = lsbf ? {o_mosi, srx[DW-1:1]} : {srx[DW-2:0], o_mosi};
                end else if (sb < DW) begin
                    miso = lsbf ? slv[sb] : slv[DW-1-sb];
                    sb++;
                end
                prev = o_sclk;
            end
            if (loopb) miso = o_mosi;
            if (o_stb) begin
                stb_at = c;
                mrx = o_rd;
                exp_w = exp_q.pop_front();
                tests++;
                if (o_rd !== exp_w) begin
                    fails++; $display("FAIL rx_word: got %h expected %h", o_rd, exp_w);
                end
                tests++;
                if (o_cs !== 4'hF || o_busy !== 1'b1 || o_mosi !== 1'b0) begin
                    fails++;
                    $display("FAIL done_cycle: cs=%b busy=%b mosi=%b expected cs=1111 busy=1 mosi=0",
                             o_cs, o_busy, o_mosi);
                end
            end
            if (noise) begin
                en = ($urandom_range(0, 1) == 1) || (stb_at > 0);
                data = DW'($urandom); sel = 2'($urandom); cpol_drv = 1'($urandom);
                cpha_drv = 1'($urandom); lsb_drv = 1'($urandom);
            end else begin
                en = 1'b0;
            end
        end
        tests++;
        if (stb_at != lat) begin
            fails++; $display("FAIL strobe_latency: got %0d expected %0d", stb_at, lat);
        end
        if (!loopb) begin
            tests++;
            if (srx !== tx) begin
                fails++; $display("FAIL slave_rx: got %h expected %h", srx, tx);
            end
        end
        tests++;
        if (trans != 2 * DW || rises != DW) begin
            fails++;
            $display("FAIL sclk_edges: got %0d transitions %0d rising expected %0d and %0d",
                     trans, rises, 2 * DW, DW);
        end
        tests++;
        if (first_bit !== (lsbf ? tx[0] : tx[DW-1])) begin
            fails++; $display("FAIL first_mosi_bit: got %b expected %b", first_bit,
                              lsbf ? tx[0] : tx[DW-1]);
        end
        tests++;
        if (cs_bad != 0 || busy_bad != 0) begin
            fails++; $display("FAIL cs_busy_during_xfer: got %0d bad cs and %0d bad busy cycles expected 0",
                              cs_bad, busy_bad);
        end
        if (noise) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                en = 1'b0;
                if (o_busy !== 1'b0 || o_stb !== 1'b0 || o_cs !== 4'hF) post_bad++;
                if (stb_at > 0 && o_rd !== mrx) post_bad++;
            end
            tests++;
            if (post_bad != 0) begin
                fails++; $display("FAIL ignored_starts: got %0d bad idle cycles expected 0", post_bad);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; which = 1'b0; data = '0; sel = '0;
        cpol_drv = 1'b1; cpha_drv = 1'b0; lsb_drv = 1'b0; miso = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (cs0 !== 4'hF || cs1 !== 3'h7) begin
            fails++; $display("FAIL reset_cs: got %b/%b expected 1111/111", cs0, cs1);
        end
        tests++;
        if ({sclk0, sclk1, mosi0, mosi1} !== 4'b0) begin
            fails++; $display("FAIL reset_sclk_mosi: got %b expected 0000", {sclk0, sclk1, mosi0, mosi1});
        end
        tests++;
        if ({busy0, busy1, stb0, stb1} !== 4'b0) begin
            fails++; $display("FAIL reset_busy_strobe: got %b expected 0000", {busy0, busy1, stb0, stb1});
        end
        tests++;
        if (rd0 !== '0 || rd1 !== '0) begin
            fails++; $display("FAIL reset_rdata: got %h/%h expected 00/00", rd0, rd1);
        end
        rst = 1'b0;
    endtask

    task automatic test_mode0_loopback();
        xfer(1'b0, 8'hA5, 8'h00, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_mode3_slave();
        xfer(1'b0, 8'hC3, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_div1_modes();
        xfer(1'b1, 8'hC3, 8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(1'b1, 8'hC3, 8'h3C, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_invalid_select();
        int cs_bad, busy_bad, stb_bad;
        cs_bad = 0; busy_bad = 0; stb_bad = 0;
        @(negedge clk);
        which = 1'b1; sel = 2'd3; data = 8'h5A; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cs1 !== 3'b111) cs_bad++;
            if (busy1 !== 1'b0) busy_bad++;
            if (stb1 !== 1'b0) stb_bad++;
        end
        en = 1'b0;
        tests++;
        if (cs_bad != 0) begin fails++; $display("FAIL invalid_sel_cs: got %0d low cycles expected 0", cs_bad); end
        tests++;
        if (busy_bad != 0) begin fails++; $display("FAIL invalid_sel_busy: got %0d busy cycles expected 0", busy_bad); end
        tests++;
        if (stb_bad != 0) begin fails++; $display("FAIL invalid_sel_strobe: got %0d strobes expected 0", stb_bad); end
    endtask

    task automatic test_busy_ignore();
        xfer(1'b0, 8'h96, 8'h69, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        xfer(1'b1, 8'h0F, 8'hF0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        xfer(1'b0, 8'h81, 8'h7E, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 8'h42, 8'hBD, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_xfer();
        int bad;
        bad = 0;
        @(negedge clk);
        which = 1'b0; cpol_drv = 1'b1; cpha_drv = 1'b1;
        repeat (2) @(negedge clk);
        data = 8'hE7; sel = 2'd2; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (cs0 !== 4'hF || sclk0 !== 1'b0 || busy0 !== 1'b0 || stb0 !== 1'b0 || mosi0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_xfer: cs=%b sclk=%b busy=%b strobe=%b mosi=%b expected 1111 0 0 0 0",
                     cs0, sclk0, busy0, stb0, mosi0);
        end
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (stb0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL reset_no_strobe: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_random();
        bit u, lb, lsbr;
        logic [1:0] s;
        for (int n = 0; n < 12; n++) begin
            u = 1'($urandom);
            s = u ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            lb = ($urandom_range(0, 3) == 0);
            lsbr = 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsbr = 1'($urandom);
`endif
            xfer(u, DW'($urandom), DW'($urandom), s, 1'($urandom), 1'($urandom),
                 lb, 1'($urandom), 1'b1, lsbr);
        end
    endtask

`ifdef SPI_LSB_FIRST_EN
    task automatic test_lsb_first();
        xfer(1'b0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        xfer(1'b1, 8'h35, 8'hA6, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_div1_modes();
        test_invalid_select();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_xfer();
        test_random();
`ifdef SPI_LSB_FIRST_EN
        test_lsb_first();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: got %0d words pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised next-generation SPI master: configurable word width, SCLK divider and chip-select count.
- Runtime-selectable SPI mode (CPOL/CPHA), captured per transfer.
- Full-duplex: shifts one word out on mosi while capturing one word from miso, then pulses a receive strobe.
- Drives multiple slave_s on a shared bus through one-hot, active-low chip selects.

Parameters:
- DATA_W, 8: bits per transfer; legal range 2..32.
- NUM_CS, 4: number of chip-select lines; legal range 1..16.
- CLK_DIV, 2: SCLK half-period in clk cycles; must be ≥1.
- CS_SEL_W, max(1,$clog2(NUM_CS)): width of cs_sel. Derived; do not override.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- data_send_enable  in  1  start request; sampled only in IDLE.
- data_send_master  in  DATA_W  transmit word; latched on the accepted start.
- cs_sel  in  CS_SEL_W  target slave index; latched on the accepted start.
- cpol  in  1  SCLK idle level; latched on the accepted start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on the accepted start.
- miso  in  1  serial data from slave.
- mosi  out  1  serial data to slave; MSB first.
- sclk  out  1  serial clock.
- cs  out  NUM_CS  active-low chip selects; at most one is low at any time.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- data_receive_master  out  DATA_W  received word; holds its value until the next DONE.
- data_receive_master_enable  out  1  one-cycle strobe; data_receive_master is valid in that cycle.

Behaviour:
- Reset values (all registered): cs = all ones, sclk = 0, mosi = 0, busy = 0, data_receive_master = 0, data_receive_master_enable = 0, state = IDLE.
- States: IDLE → LEAD → XFER → TRAIL → DONE → IDLE.
- IDLE:
  - sclk follows the cpol input, one register stage late.
  - A start is accepted when data_send_enable = 1 and cs_sel < NUM_CS. On acceptance, latch the word, cs_sel and mode, then go to LEAD.
  - If cs_sel ≥ NUM_CS the request is ignored: no transfer, no strobe.
- LEAD: CLK_DIV cycles. cs[sel] = 0, sclk = cpol. If cpha = 0, mosi = bit DATA_W-1 from the first LEAD cycle.
- XFER: 2*DATA_W half-periods of CLK_DIV cycles each.
  - In half-period k (k = 1..2*DATA_W), sclk = cpol XOR (k odd). Odd k is a leading edge, even k is a trailing edge.
  - Sample edges: leading if cpha = 0, trailing if cpha = 1. Shift edges are the other type.
  - For cpha = 0, the shift on edge 2*DATA_W is suppressed.
  - For cpha = 1, mosi drives bit DATA_W-1 at edge 1.
  - mosi changes in the same clk cycle that sclk makes a shift transition.
  - miso is captured into the receive shift register at the end of the first clk cycle of each sample half-period, MSB first.
- TRAIL: CLK_DIV cycles. sclk = cpol, cs[sel] stays low, mosi holds.
- DONE: one cycle.
  - cs = all ones, mosi = 0, busy = 1.
  - data_receive_master updates and data_receive_master_enable = 1 in this cycle.
  - Next state is IDLE.
- Latency: for a start accepted at the clk edge ending cycle T, DONE occurs in cycle T + (2*DATA_W + 2)*CLK_DIV + 1. For the defaults this is T + 37.
- Back-to-back: a start asserted in the DONE cycle is ignored. The earliest next start is the first IDLE cycle.
- Input changes while busy: changes to data_send_master, cs_sel, cpol or cpha have no effect.
- Reset mid-transfer: all outputs return to reset values on the next edge. No strobe is produced.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined:
  - Adds input port lsb_first (1 bit), latched on the accepted start.
  - When lsb_first = 1, mosi shifts bit 0 first and received bits fill from bit DATA_W-1 downward, so data_receive_master is in natural order.
  - When lsb_first = 0, behaviour is MSB-first as above.
- Undefined: the port is absent and all transfers are MSB-first.

Test Plan:
- Mode 0 loopback: DATA_W=8, CLK_DIV=2, miso tied to mosi, send 0xA5 on cs_sel=1 → cs = 4'b1101 during transfer, 8 rising sclk edges, strobe at T+37, data_receive_master = 0xA5.
- Mode 3 against a slave model returning 0x3C while master sends 0xC3 → sclk idles high, slave sees 0xC3, master receives 0x3C, exactly 16 sclk transitions.
- Mode 1 and mode 2, CLK_DIV=1, same exchange → correct data in both directions, DONE at T+19.
- Invalid select: NUM_CS=3, cs_sel=3 → cs stays 3'b111, busy stays 0, no strobe.
- Start pulse during busy and during DONE → ignored, exactly one strobe produced. rst asserted mid-XFER → next cycle cs = all ones, sclk = 0, busy = 0, no strobe.
- With SPI_LSB_FIRST_EN defined, lsb_first=1, send 0x01 → mosi = 1 on the first bit, loopback data_receive_master = 0x01.
